// File: rtl/spectrum_pkg.sv
// Shared types and arithmetic for the spectrum frame builder.
// A bin is a complex pair of signed saturating accumulators.
package spectrum_pkg;

  localparam int unsigned N_BINS     = 2048;
  localparam int unsigned K_WIDTH    = 12;
  localparam int unsigned IDX_WIDTH  = 11;
  localparam int unsigned COMP_WIDTH = 40;

  typedef struct packed {
    logic signed [COMP_WIDTH-1:0] im;
    logic signed [COMP_WIDTH-1:0] re;
  } cplx_t;

  typedef struct packed {
    logic signed [COMP_WIDTH-1:0] sum;
    logic                         saturated;
  } sat_res_t;

  typedef enum logic [1:0] {CLEAR, COLLECT, DRAIN} builder_state_t;

  // One extra bit holds the exact sum; the two top bits disagree on overflow.
  function automatic sat_res_t sat_add_comp(input logic signed [COMP_WIDTH-1:0] a,
                                            input logic signed [COMP_WIDTH-1:0] b);
    logic signed [COMP_WIDTH:0] s;
    sat_res_t r;
    s = {a[COMP_WIDTH-1], a} + {b[COMP_WIDTH-1], b};
    r.saturated = (s[COMP_WIDTH] != s[COMP_WIDTH-1]);
    if (!r.saturated)      r.sum = s[COMP_WIDTH-1:0];
    else if (s[COMP_WIDTH]) r.sum = {1'b1, {(COMP_WIDTH-1){1'b0}}};
    else                    r.sum = {1'b0, {(COMP_WIDTH-1){1'b1}}};
    return r;
  endfunction

endpackage

// File: rtl/spectrum_frame_builder_if.sv
// Input bin stream, output frame stream and saturation flag of the builder.
interface spectrum_frame_builder_if;
  import spectrum_pkg::*;

  cplx_t                in_data;
  logic [K_WIDTH-1:0]   in_k;
  logic                 in_valid;
  logic                 in_last;
  logic                 in_ready;
  cplx_t                out_data;
  logic [IDX_WIDTH-1:0] out_index;
  logic                 out_valid;
  logic                 out_last;
  logic                 out_ready;
  logic                 sat_pulse;

  modport slave (
    input  in_data, in_k, in_valid, in_last, out_ready,
    output in_ready, out_data, out_index, out_valid, out_last, sat_pulse
  );

  modport master (
    output in_data, in_k, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_index, out_valid, out_last, sat_pulse
  );
endinterface

// File: rtl/spectrum_frame_builder_bin_ram.sv
// Frame buffer: N_BINS complex bins, two asynchronous read ports, one synchronous write port.
module bin_ram
  import spectrum_pkg::*;
(
  input  logic                 clk,
  input  logic                 we,
  input  logic [IDX_WIDTH-1:0] waddr,
  input  cplx_t                wdata,
  input  logic [IDX_WIDTH-1:0] raddr_a,
  output cplx_t                rdata_a,
  input  logic [IDX_WIDTH-1:0] raddr_b,
  output cplx_t                rdata_b
);

  cplx_t mem_q [N_BINS];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/spectrum_frame_builder.sv
// Accumulates resampled bins into one frame, then streams the ordered frame out,
// clearing each bin as it is consumed.
module spectrum_frame_builder
  import spectrum_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  spectrum_frame_builder_if.slave bus
);

  localparam logic [K_WIDTH-1:0]   K_LIMIT  = K_WIDTH'(N_BINS);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_BINS - 1);

  builder_state_t       state_q, state_d;
  logic [IDX_WIDTH-1:0] clr_idx_q, clr_idx_d;
  logic [IDX_WIDTH-1:0] rd_idx_q, rd_idx_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic [IDX_WIDTH-1:0] out_index_q, out_index_d;
  logic                 sat_pulse_q, sat_pulse_d;

  logic                 ram_we;
  logic [IDX_WIDTH-1:0] ram_waddr;
  cplx_t                ram_wdata;
  cplx_t                acc_rd;
  cplx_t                drain_rd;
  sat_res_t             sat_re, sat_im;
  logic                 accept, handshake;

  bin_ram u_bin_ram (
    .clk     (clk),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .raddr_a (bus.in_k[IDX_WIDTH-1:0]),
    .rdata_a (acc_rd),
    .raddr_b (rd_idx_q),
    .rdata_b (drain_rd)
  );

  assign accept    = bus.in_valid && in_ready_q;
  assign handshake = out_valid_q && bus.out_ready;
  assign sat_re    = sat_add_comp(acc_rd.re, bus.in_data.re);
  assign sat_im    = sat_add_comp(acc_rd.im, bus.in_data.im);

  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    rd_idx_d    = rd_idx_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_index_d = out_index_q;
    sat_pulse_d = 1'b0;
    ram_we      = 1'b0;
    ram_waddr   = rd_idx_q;
    ram_wdata   = '0;

    unique case (state_q)
      CLEAR: begin
        ram_we     = 1'b1;
        ram_waddr  = clr_idx_q;
        clr_idx_d  = clr_idx_q + IDX_WIDTH'(1);
        in_ready_d = (clr_idx_q == LAST_IDX);
        if (clr_idx_q == LAST_IDX) state_d = COLLECT;
      end
      COLLECT: begin
        if (accept) begin
          if (bus.in_k < K_LIMIT) begin
            ram_we       = 1'b1;
            ram_waddr    = bus.in_k[IDX_WIDTH-1:0];
            ram_wdata.re = sat_re.sum;
            ram_wdata.im = sat_im.sum;
            sat_pulse_d  = sat_re.saturated || sat_im.saturated;
          end
          if (bus.in_last) begin
            state_d     = DRAIN;
            rd_idx_d    = '0;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
            out_index_d = '0;
            out_last_d  = 1'b0;
          end
        end
      end
      DRAIN: begin
        // Clear-on-read leaves the buffer zeroed for the next frame.
        if (handshake) begin
          ram_we    = 1'b1;
          ram_waddr = rd_idx_q;
          if (rd_idx_q == LAST_IDX) begin
            state_d     = COLLECT;
            rd_idx_d    = '0;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            rd_idx_d    = rd_idx_q + IDX_WIDTH'(1);
            out_index_d = rd_idx_q + IDX_WIDTH'(1);
            out_last_d  = ((rd_idx_q + IDX_WIDTH'(1)) == LAST_IDX);
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= CLEAR;
      clr_idx_q   <= '0;
      rd_idx_q    <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_index_q <= '0;
      sat_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      rd_idx_q    <= rd_idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_index_q <= out_index_d;
      sat_pulse_q <= sat_pulse_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_index = out_index_q;
  assign bus.out_data  = drain_rd;
  assign bus.sat_pulse = sat_pulse_q;

endmodule

// File: tb/tb_spectrum_frame_builder.sv
// Bench for spectrum_frame_builder: frame-level model of accumulated bins checked
// every cycle, plus directed frames with hand-computed expectations.
module tb_spectrum_frame_builder;
  import spectrum_pkg::*;

  localparam longint MAXV = 64'sd549755813887;
  localparam longint MINV = -64'sd549755813888;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spectrum_frame_builder_if bus ();

  spectrum_frame_builder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic signed [COMP_WIDTH-1:0] m_re [N_BINS];
  logic signed [COMP_WIDTH-1:0] m_im [N_BINS];
  logic signed [COMP_WIDTH-1:0] cap_re [N_BINS];
  logic signed [COMP_WIDTH-1:0] cap_im [N_BINS];
  int     exp_idx = 0;
  logic   exp_sat = 1'b0;
  logic   sat_now;
  longint sr, si;
  int     kk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: a bin is the clamped running sum of every in-range beat since it was last read.
  always @(posedge clk) begin
    if (rst !== 1'b1) begin
      for (int i = 0; i < int'(N_BINS); i++) begin
        m_re[i] = '0;
        m_im[i] = '0;
      end
      exp_idx = 0;
      exp_sat = 1'b0;
    end else begin
      sat_now = 1'b0;
      if (bus.in_valid && bus.in_ready) begin
        kk = int'(bus.in_k);
        if (kk < int'(N_BINS)) begin
          sr = longint'(m_re[kk]) + longint'(bus.in_data.re);
          si = longint'(m_im[kk]) + longint'(bus.in_data.im);
          if (sr > MAXV) begin sr = MAXV; sat_now = 1'b1; end
          if (sr < MINV) begin sr = MINV; sat_now = 1'b1; end
          if (si > MAXV) begin si = MAXV; sat_now = 1'b1; end
          if (si < MINV) begin si = MINV; sat_now = 1'b1; end
          m_re[kk] = 40'(sr);
          m_im[kk] = 40'(si);
        end
        if (bus.in_last) exp_idx = 0;
      end
      if (bus.out_valid && bus.out_ready) begin
        m_re[exp_idx] = '0;
        m_im[exp_idx] = '0;
        exp_idx = (exp_idx + 1) % int'(N_BINS);
      end
      exp_sat = sat_now;
    end
  end

  // Per-cycle comparison of the output stream against the model.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      chk("sat_pulse", longint'(bus.sat_pulse), longint'(exp_sat));
      if (bus.out_valid) begin
        chk("out_index", longint'(bus.out_index), longint'(exp_idx));
        chk("out_re", longint'(bus.out_data.re), longint'(m_re[exp_idx]));
        chk("out_im", longint'(bus.out_data.im), longint'(m_im[exp_idx]));
        chk("out_last", longint'(bus.out_last), longint'(exp_idx == int'(N_BINS) - 1));
      end
    end
  end

  task automatic send(input int k, input longint re, input longint im, input bit last);
    int g;
    bus.in_k       = 12'(k);
    bus.in_data.re = 40'(re);
    bus.in_data.im = 40'(im);
    bus.in_last    = last;
    bus.in_valid   = 1'b1;
    g = 0;
    while (!bus.in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!bus.in_ready) chk("send_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // mode 0: out_ready always high; mode 1: out_ready pattern 1,0,0 repeating.
  task automatic drain(input int mode, output int beats, output int nz);
    int cyc;
    cyc = 0; beats = 0; nz = 0;
    for (int i = 0; i < int'(N_BINS); i++) begin
      cap_re[i] = '0;
      cap_im[i] = '0;
    end
    while (!bus.in_ready && cyc < 10000) begin
      bus.out_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      if (bus.out_valid && bus.out_ready) begin
        beats++;
        cap_re[bus.out_index] = bus.out_data.re;
        cap_im[bus.out_index] = bus.out_data.im;
        if (bus.out_data != '0) nz++;
      end
      @(negedge clk);
      cyc++;
    end
    if (!bus.in_ready) chk("drain_timeout", 0, 1);
    bus.out_ready = 1'b1;
  endtask

  task automatic clear_check(input string name);
    int cnt;
    int seen_valid;
    cnt = 0; seen_valid = 0;
    while (!bus.in_ready && cnt < 3000) begin
      if (bus.out_valid) seen_valid++;
      cnt++;
      @(negedge clk);
    end
    chk({name, "_len"}, cnt, 2048);
    chk({name, "_valid"}, seen_valid, 0);
  endtask

  int beats, nz, g;

  initial begin
    rst = 1'b0;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_k = '0; bus.in_data = '0;
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", longint'(bus.in_ready), 0);
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_out_index", longint'(bus.out_index), 0);
    rst = 1'b1;
    clear_check("clear0");

    // Identity frame.
    for (int k = 0; k < int'(N_BINS); k++) send(k, 2 * k, 0, k == int'(N_BINS) - 1);
    idle();
    chk("id_valid_rise", longint'(bus.out_valid), 1);
    chk("id_first_idx", longint'(bus.out_index), 0);
    drain(0, beats, nz);
    chk("id_beats", beats, 2048);
    chk("id_re1000", longint'(cap_re[1000]), 2000);
    chk("id_re2047", longint'(cap_re[2047]), 4094);
    chk("id_ready_after", longint'(bus.in_ready), 1);
    chk("id_valid_after", longint'(bus.out_valid), 0);

    // Collisions and gaps.
    send(5, 100, 0, 0);
    send(5, -30, 0, 0);
    send(9, 0, -7, 1);
    idle();
    drain(0, beats, nz);
    chk("col_re5", longint'(cap_re[5]), 70);
    chk("col_im9", longint'(cap_im[9]), -7);
    chk("col_nz", nz, 2);

    // Out-of-range indices are dropped.
    send(2048, 1, 1, 0);
    send(3000, 2, 2, 0);
    send(4095, 3, 3, 1);
    idle();
    drain(0, beats, nz);
    chk("oor_beats", beats, 2048);
    chk("oor_nz", nz, 0);

    // Saturation.
    send(1, MAXV, 0, 0);
    chk("sat_first", longint'(bus.sat_pulse), 0);
    send(1, MAXV, 0, 0);
    chk("sat_re_pulse", longint'(bus.sat_pulse), 1);
    send(2, 0, MINV, 0);
    chk("sat_third", longint'(bus.sat_pulse), 0);
    send(2, 0, MINV, 1);
    chk("sat_im_pulse", longint'(bus.sat_pulse), 1);
    idle();
    drain(0, beats, nz);
    chk("sat_re1", longint'(cap_re[1]), MAXV);
    chk("sat_im2", longint'(cap_im[2]), MINV);

    // Backpressure.
    for (int k = 0; k < 200; k++) send(k, k + 1, -k, k == 199);
    idle();
    drain(1, beats, nz);
    chk("bp_beats", beats, 2048);
    chk("bp_nz", nz, 200);
    chk("bp_re150", longint'(cap_re[150]), 151);
    chk("bp_im150", longint'(cap_im[150]), -150);

    // Buffer must be empty after clear-on-read.
    send(3, 1, 0, 1);
    idle();
    drain(0, beats, nz);
    chk("cor_nz", nz, 1);
    chk("cor_re3", longint'(cap_re[3]), 1);

    // Reset in the middle of a drain.
    send(500, 5, 5, 1);
    idle();
    g = 0;
    while (!(bus.out_valid && bus.out_index == 11'd100) && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk("abort_reach", longint'(bus.out_index), 100);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_valid", longint'(bus.out_valid), 0);
    chk("abort_ready", longint'(bus.in_ready), 0);
    rst = 1'b1;
    clear_check("clear1");
    send(4, 9, 0, 1);
    idle();
    drain(0, beats, nz);
    chk("post_nz", nz, 1);
    chk("post_re4", longint'(cap_re[4]), 9);
    chk("post_re500", longint'(cap_re[500]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
